fpu_addsub_param: RTL and testbench
===================================

// Module: fpu_addsub_param
// PURPOSE
//  Parametrised floating-point adder/subtractor with start/done handshake and selectable rounding.
//  Format is {sign, EXP_W exponent (bias 2^(EXP_W-1)-1), MAN_W mantissa}; exponent 0 = zero (denormals
//  flushed), exponent all-ones = inf (man==0) or NaN (man!=0). Sits beside the datapath as a multi-cycle
//  arithmetic unit; defaults reproduce the 32-bit 1/10/21 format used across the design.
// PARAMETERS
//  EXP_W   10   exponent width (>=4)
//  MAN_W   21   stored mantissa width (>=4); word width W = 1+EXP_W+MAN_W
// PORTS
//  clock_100KHz  in   1       system clock
//  reset         in   1       asynchronous, active-low
//  start_in      in   1       request; accepted only while ready_out=1
//  op_in         in   1       0 = A+B, 1 = A-B (sign of B inverted at capture)
//  rnd_mode_in   in   1       0 = round-to-nearest-even, 1 = truncate (toward zero)
//  op_A_in       in   W       operand A, sampled on the accepting edge
//  op_B_in       in   W       operand B, sampled on the accepting edge
//  ready_out     out  1       1 in IDLE only
//  done_out      out  1       1-cycle pulse; data_out/status_out valid from this cycle
//  data_out      out  W       result, held until next done_out
//  status_out    out  4       0001 EXACT, 0010 OVERFLOW, 0100 UNDERFLOW, 1000 INEXACT (one-hot)
// BEHAVIOUR
//  Reset (any time, incl. mid-operation): state IDLE, ready_out=1, done_out=0, data_out=0, status_out=0000.
//  FSM: IDLE -> UNPACK -> SPECIAL -> {PACK | ALIGN -> ADDSUB -> NORM -> ROUND -> PACK} -> IDLE.
//  Capture: the edge seeing start_in&&ready_out latches A, B, op_in and rnd_mode_in; start_in at other times is ignored.
//  Latency: done_out high exactly 7 edges after capture edge (normal path), 3 edges (special path).
//  Back-to-back: start_in may be asserted in the done_out cycle (FSM already IDLE); it is accepted.
//  SPECIAL priority: any NaN -> {0,all-ones,1}, INEXACT; inf+(-inf) -> same NaN, INEXACT;
//   one inf -> that inf, EXACT; A zero -> B (with op sign applied), EXACT; B zero -> A, EXACT.
//  ALIGN: larger-exponent operand is A (swap incl. signs); B = {1,man,G,R,S} shifted right by diff,
//   shifted-out bits ORed into S; diff > MAN_W+2 -> B reduced to S=1 only.
//  ADDSUB: MAN_W+5-bit magnitude; same signs add, else larger minus smaller, sign of larger;
//   exact zero -> +0, EXACT, go to PACK.
//  NORM: single cycle, via leading-zero count: carry -> >>1 (bit into S), exp+1; else << lzc, exp-lzc.
//  ROUND: RNE increments when G&&(R||S||lsb); truncate never increments. INEXACT if G|R|S.
//   mantissa carry-out -> man=0, exp+1.
//  Range: exp after ROUND >= all-ones -> ±inf, OVERFLOW; exp <= 0 -> +0, UNDERFLOW (overrides INEXACT).
//  Exponent arithmetic held in EXP_W+2 signed bits so over/underflow never wraps.
// STRUCTURE
//  fpu_pkg: status enum (ESPERA/EXACT/OVERFLOW/UNDERFLOW/INEXACT), FSM state enum, RND_RNE/RND_RTZ constants.
//  Sub-module fpu_lzc #(WIDTH): combinational leading-zero counter used by NORM.
// TESTING (defaults; 1.0 = 0x3FE00000)
//  1.0+1.0 (0x3FE00000,0x3FE00000,op 0) -> 0x40000000, 0001, done 7 edges after capture.
//  1.0-1.0 (op 1) -> 0x00000000, 0001; 0x7FDFFFFF+0x7FDFFFFF -> 0x7FE00000, 0010.
//  0x3FE00001+0x3D200000 (tie, odd lsb): RNE -> 0x3FE00002, 1000; truncate -> 0x3FE00001, 1000.
//  A=0x7FE00005 -> 0x7FE00001, 1000, done 3 edges after capture; 0x7FE00000 + 0xFFE00000 -> 0x7FE00001, 1000.
//  start_in pulsed during ALIGN -> ignored, single done_out; reset dropped in NORM -> all outputs 0, ready_out=1.
//  Random sweep vs. real-valued model across EXP_W=8/MAN_W=15 and defaults; status one-hot every done_out.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types for the floating-point add/sub unit. Holds the
//               one-hot result status encoding, the controller state encoding
//               and the rounding-mode selector values.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  // One-hot completion status; ESPERA is the idle/reset value.
  typedef enum logic [3:0] {
    ESPERA    = 4'b0000,
    EXACT     = 4'b0001,
    OVERFLOW  = 4'b0010,
    UNDERFLOW = 4'b0100,
    INEXACT   = 4'b1000
  } status_e;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    ALIGN   = 3'd3,
    ADDSUB  = 3'd4,
    NORM    = 3'd5,
    ROUND   = 3'd6,
    PACK    = 3'd7
  } state_e;

  // Rounding-mode selector values for rnd_mode_in.
  localparam logic RND_RNE = 1'b0;
  localparam logic RND_RTZ = 1'b1;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// ============================================================================
// Module      : fpu_lzc
// Description : Combinational leading-zero counter.
//   value_in  in  WIDTH               vector to scan (MSB first)
//   count_out out clog2(WIDTH+1)      number of zeros above the first one;
//                                     WIDTH when value_in is all zeros
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_lzc #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0]         value_in,
  output logic [$clog2(WIDTH+1)-1:0] count_out
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_out = c_cnt_w'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value_in[i]) begin
        count_out = c_cnt_w'(WIDTH - 1 - i);
      end
    end
  end

endmodule : fpu_lzc
`default_nettype wire

// File: rtl/fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub_param
// Description : Multi-cycle floating-point adder/subtractor with start/done
//               handshake and selectable rounding (nearest-even / truncate).
//               Word = {sign, EXP_W exponent (bias 2^(EXP_W-1)-1), MAN_W
//               mantissa}; exponent 0 is zero (denormals flushed), exponent
//               all-ones is inf (man==0) or NaN (man!=0).
//   clock_100KHz in   1  system clock
//   reset        in   1  asynchronous, active-low
//   start_in     in   1  request, accepted only while ready_out=1
//   op_in        in   1  0: A+B, 1: A-B
//   rnd_mode_in  in   1  0: round-to-nearest-even, 1: truncate
//   op_A_in      in   W  operand A
//   op_B_in      in   W  operand B
//   ready_out    out  1  high while idle
//   done_out     out  1  one-cycle completion pulse
//   data_out     out  W  result, held until the next completion
//   status_out   out  4  one-hot EXACT/OVERFLOW/UNDERFLOW/INEXACT
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int MAN_W = 21
) (
  input  logic                     clock_100KHz,
  input  logic                     reset,
  input  logic                     start_in,
  input  logic                     op_in,
  input  logic                     rnd_mode_in,
  input  logic [EXP_W+MAN_W:0]     op_A_in,
  input  logic [EXP_W+MAN_W:0]     op_B_in,
  output logic                     ready_out,
  output logic                     done_out,
  output logic [EXP_W+MAN_W:0]     data_out,
  output logic [3:0]               status_out
);

  localparam int c_w   = 1 + EXP_W + MAN_W;  // word width
  localparam int c_xw  = MAN_W + 4;          // {1, man, G, R, S}
  localparam int c_mgw = MAN_W + 5;          // magnitude incl. carry
  localparam int c_exw = EXP_W + 2;          // two's-complement exponent
  localparam int c_mw1 = MAN_W + 1;
  localparam int c_lzw = $clog2(c_xw + 1);

  localparam logic [c_exw-1:0] c_exp_max = {2'b00, {EXP_W{1'b1}}};
  localparam logic [c_w-1:0]   c_nan     =
    {1'b0, {EXP_W{1'b1}}, {{(MAN_W-1){1'b0}}, 1'b1}};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_e              r_state;
  state_e              w_next_state;

  logic [c_w-1:0]      r_a, r_b;          // B already carries the op sign
  logic                r_rnd;
  logic                r_a_nan, r_a_inf, r_a_zero;
  logic                r_b_nan, r_b_inf, r_b_zero;
  logic                r_sa, r_sb;        // signs after swap (A = larger exp)
  logic [c_xw-1:0]     r_xa, r_xb;        // aligned extended mantissas
  logic [c_exw-1:0]    r_er;              // working exponent
  logic [c_mgw-1:0]    r_mag;
  logic                r_sr;              // result sign
  logic [c_xw-1:0]     r_nx;              // normalised mantissa with G/R/S
  logic [c_exw-1:0]    r_ne;
  logic [c_w-1:0]      r_res;
  status_e             r_stat;

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic                w_sa, w_sb;
  logic [EXP_W-1:0]    w_ea, w_eb;
  logic [MAN_W-1:0]    w_ma, w_mb;

  assign w_sa = r_a[c_w-1];
  assign w_sb = r_b[c_w-1];
  assign w_ea = r_a[c_w-2 -: EXP_W];
  assign w_eb = r_b[c_w-2 -: EXP_W];
  assign w_ma = r_a[MAN_W-1:0];
  assign w_mb = r_b[MAN_W-1:0];

  assign ready_out = (r_state == IDLE);

  // --------------------------------------------------------------------------
  // SPECIAL: NaN / inf / zero short-cuts, in priority order
  // --------------------------------------------------------------------------
  logic                w_special;
  logic [c_w-1:0]      w_spec_res;
  status_e             w_spec_stat;

  always_comb begin
    w_special   = r_a_nan | r_b_nan | r_a_inf | r_b_inf | r_a_zero | r_b_zero;
    w_spec_res  = '0;
    w_spec_stat = EXACT;
    if (r_a_nan || r_b_nan) begin
      w_spec_res  = c_nan;
      w_spec_stat = INEXACT;
    end else if (r_a_inf && r_b_inf && (w_sa != w_sb)) begin
      w_spec_res  = c_nan;
      w_spec_stat = INEXACT;
    end else if (r_a_inf) begin
      w_spec_res  = r_a;
    end else if (r_b_inf) begin
      w_spec_res  = r_b;
    end else if (r_a_zero) begin
      w_spec_res  = r_b;
    end else if (r_b_zero) begin
      w_spec_res  = r_a;
    end
  end

  // --------------------------------------------------------------------------
  // ALIGN: put the larger exponent in A, shift B right with sticky collection
  // --------------------------------------------------------------------------
  logic                w_swap;
  logic [EXP_W-1:0]    w_el, w_es, w_diff;
  logic [c_xw-1:0]     w_xl, w_xs, w_xs_sh;
  logic                w_sl, w_ss, w_sticky;
  int                  w_diff_i;

  always_comb begin
    w_swap   = (w_eb > w_ea);
    w_el     = w_swap ? w_eb : w_ea;
    w_es     = w_swap ? w_ea : w_eb;
    w_sl     = w_swap ? w_sb : w_sa;
    w_ss     = w_swap ? w_sa : w_sb;
    w_xl     = {1'b1, (w_swap ? w_mb : w_ma), 3'b000};
    w_xs     = {1'b1, (w_swap ? w_ma : w_mb), 3'b000};
    w_diff   = w_el - w_es;
    w_diff_i = int'(w_diff);
    w_sticky = 1'b0;
    w_xs_sh  = '0;
    if (w_diff_i > MAN_W + 2) begin
      // Everything would land below S: only the sticky bit survives.
      w_xs_sh = c_xw'(1);
    end else begin
      w_xs_sh = w_xs >> w_diff;
      for (int i = 0; i < c_xw; i++) begin
        if (i < w_diff_i) begin
          w_sticky = w_sticky | w_xs[i];
        end
      end
      w_xs_sh[0] = w_xs_sh[0] | w_sticky;
    end
  end

  // --------------------------------------------------------------------------
  // ADDSUB: sign-magnitude add; unlike signs subtract smaller from larger
  // --------------------------------------------------------------------------
  logic [c_mgw-1:0]    w_mag;
  logic                w_sr;

  always_comb begin
    w_mag = '0;
    w_sr  = r_sa;
    if (r_sa == r_sb) begin
      w_mag = {1'b0, r_xa} + {1'b0, r_xb};
    end else if (r_xa >= r_xb) begin
      w_mag = {1'b0, r_xa} - {1'b0, r_xb};
    end else begin
      w_mag = {1'b0, r_xb} - {1'b0, r_xa};
      w_sr  = r_sb;
    end
  end

  // --------------------------------------------------------------------------
  // NORM: leading-zero count below the carry position
  // --------------------------------------------------------------------------
  logic [c_lzw-1:0]    w_lzc;

  fpu_lzc #(
    .WIDTH     (c_xw)
  ) u_lzc (
    .value_in  (r_mag[c_xw-1:0]),
    .count_out (w_lzc)
  );

  // --------------------------------------------------------------------------
  // ROUND and range check
  // --------------------------------------------------------------------------
  logic                w_g, w_r, w_s, w_inc, w_inexact;
  logic [MAN_W:0]      w_man_rnd;
  logic [c_exw-1:0]    w_exp_rnd;
  logic [c_w-1:0]      w_rnd_res;
  status_e             w_rnd_stat;

  always_comb begin
    w_g       = r_nx[2];
    w_r       = r_nx[1];
    w_s       = r_nx[0];
    w_inexact = w_g | w_r | w_s;
    w_inc     = (r_rnd == RND_RNE) && w_g && (w_r || w_s || r_nx[3]);
    // A carry out leaves the stored mantissa bits at zero, as required.
    w_man_rnd = {1'b0, r_nx[c_xw-2:3]} + c_mw1'(w_inc);
    w_exp_rnd = r_ne + c_exw'(w_man_rnd[MAN_W]);
    w_rnd_res = {r_sr, w_exp_rnd[EXP_W-1:0], w_man_rnd[MAN_W-1:0]};
    w_rnd_stat = w_inexact ? INEXACT : EXACT;
    if (!w_exp_rnd[c_exw-1] && (w_exp_rnd >= c_exp_max)) begin
      w_rnd_res  = {r_sr, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_rnd_stat = OVERFLOW;
    end else if (w_exp_rnd[c_exw-1] || (w_exp_rnd == '0)) begin
      w_rnd_res  = '0;
      w_rnd_stat = UNDERFLOW;
    end
  end

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start_in) w_next_state = UNPACK;
      UNPACK:  w_next_state = SPECIAL;
      SPECIAL: w_next_state = w_special ? PACK : ALIGN;
      ALIGN:   w_next_state = ADDSUB;
      ADDSUB:  w_next_state = (w_mag == '0) ? PACK : NORM;
      NORM:    w_next_state = ROUND;
      ROUND:   w_next_state = PACK;
      PACK:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clock_100KHz or negedge reset) begin
    if (!reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_rnd      <= RND_RNE;
      r_a_nan    <= 1'b0;
      r_a_inf    <= 1'b0;
      r_a_zero   <= 1'b0;
      r_b_nan    <= 1'b0;
      r_b_inf    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_xa       <= '0;
      r_xb       <= '0;
      r_er       <= '0;
      r_mag      <= '0;
      r_sr       <= 1'b0;
      r_nx       <= '0;
      r_ne       <= '0;
      r_res      <= '0;
      r_stat     <= ESPERA;
      done_out   <= 1'b0;
      data_out   <= '0;
      status_out <= ESPERA;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_in) begin
            r_a   <= op_A_in;
            r_b   <= {op_B_in[c_w-1] ^ op_in, op_B_in[c_w-2:0]};
            r_rnd <= rnd_mode_in;
          end
        end
        UNPACK: begin
          r_a_nan  <= (&w_ea) && (|w_ma);
          r_a_inf  <= (&w_ea) && !(|w_ma);
          r_a_zero <= (w_ea == '0);
          r_b_nan  <= (&w_eb) && (|w_mb);
          r_b_inf  <= (&w_eb) && !(|w_mb);
          r_b_zero <= (w_eb == '0);
        end
        SPECIAL: begin
          r_res  <= w_spec_res;
          r_stat <= w_spec_stat;
        end
        ALIGN: begin
          r_sa <= w_sl;
          r_sb <= w_ss;
          r_xa <= w_xl;
          r_xb <= w_xs_sh;
          r_er <= {2'b00, w_el};
        end
        ADDSUB: begin
          r_mag <= w_mag;
          r_sr  <= w_sr;
          if (w_mag == '0) begin
            r_res  <= '0;
            r_stat <= EXACT;
          end
        end
        NORM: begin
          if (r_mag[c_mgw-1]) begin
            // Carry: drop one bit into the sticky position.
            r_nx <= {r_mag[c_mgw-1:2], r_mag[1] | r_mag[0]};
            r_ne <= r_er + c_exw'(1);
          end else begin
            r_nx <= r_mag[c_xw-1:0] << w_lzc;
            r_ne <= r_er - c_exw'(w_lzc);
          end
        end
        ROUND: begin
          r_res  <= w_rnd_res;
          r_stat <= w_rnd_stat;
        end
        PACK: begin
          data_out   <= r_res;
          status_out <= r_stat;
          done_out   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : fpu_addsub_param
`default_nettype wire

// File: tb/tb_fpu_addsub_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_addsub_param
// Description : Directed self-checking bench for fpu_addsub_param with the
//               default 1/10/21 format (1.0 = 0x3FE00000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub_param;

  logic        clock_100KHz;
  logic        reset;
  logic        start_in;
  logic        op_in;
  logic        rnd_mode_in;
  logic [31:0] op_A_in;
  logic [31:0] op_B_in;
  logic        ready_out;
  logic        done_out;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int pass_cnt = 0;
  int total    = 0;

  fpu_addsub_param #(
    .EXP_W        (10),
    .MAN_W        (21)
  ) dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .start_in     (start_in),
    .op_in        (op_in),
    .rnd_mode_in  (rnd_mode_in),
    .op_A_in      (op_A_in),
    .op_B_in      (op_B_in),
    .ready_out    (ready_out),
    .done_out     (done_out),
    .data_out     (data_out),
    .status_out   (status_out)
  );

  initial clock_100KHz = 1'b0;
  always #5 clock_100KHz = ~clock_100KHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one operation, wait (bounded) for done_out and check the result.
  // exp_lat <= 0 skips the latency comparison.
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic op, input logic rnd, input logic [31:0] exp_d,
                     input logic [3:0] exp_s, input int exp_lat, input bit b2b);
    int lat;
    if (!b2b) @(negedge clock_100KHz);
    op_A_in     = a;
    op_B_in     = b;
    op_in       = op;
    rnd_mode_in = rnd;
    start_in    = 1'b1;
    @(posedge clock_100KHz); #1;
    start_in = 1'b0;
    lat = 0;
    while (done_out !== 1'b1 && lat < 20) begin
      @(posedge clock_100KHz); #1;
      lat++;
    end
    if (exp_lat > 0) check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".data"}, data_out, exp_d);
    check({tag, ".status"}, {28'd0, status_out}, {28'd0, exp_s});
  endtask

  initial begin
    int dones;
    logic [31:0] first_data;

    reset       = 1'b0;
    start_in    = 1'b0;
    op_in       = 1'b0;
    rnd_mode_in = 1'b0;
    op_A_in     = '0;
    op_B_in     = '0;
    repeat (3) @(posedge clock_100KHz);
    #1;
    check("reset.ready",  {31'd0, ready_out}, 32'd1);
    check("reset.done",   {31'd0, done_out},  32'd0);
    check("reset.data",   data_out,           32'h0);
    check("reset.status", {28'd0, status_out}, 32'h0);
    @(negedge clock_100KHz);
    reset = 1'b1;

    // Basic arithmetic
    run("one_plus_one",   32'h3FE00000, 32'h3FE00000, 1'b0, 1'b0, 32'h40000000, 4'b0001, 7, 1'b0);
    check("done_cycle.ready", {31'd0, ready_out}, 32'd1);
    run("one_minus_one",  32'h3FE00000, 32'h3FE00000, 1'b1, 1'b0, 32'h00000000, 4'b0001, 0, 1'b0);
    run("overflow",       32'h7FDFFFFF, 32'h7FDFFFFF, 1'b0, 1'b0, 32'h7FE00000, 4'b0010, 7, 1'b0);
    run("two_minus_one",  32'h40000000, 32'h3FE00000, 1'b1, 1'b0, 32'h3FE00000, 4'b0001, 7, 1'b0);
    run("one_minus_two",  32'h3FE00000, 32'h40000000, 1'b1, 1'b0, 32'hBFE00000, 4'b0001, 7, 1'b0);
    run("onefive_plus_1", 32'h3FF00000, 32'h3FE00000, 1'b0, 1'b0, 32'h40080000, 4'b0001, 7, 1'b0);
    run("neg_plus_neg",   32'hBFE00000, 32'hBFE00000, 1'b0, 1'b0, 32'hC0000000, 4'b0001, 7, 1'b0);

    // Rounding: tie with odd lsb, tie with even lsb, far operand (sticky only)
    run("tie_odd_rne",    32'h3FE00001, 32'h3D200000, 1'b0, 1'b0, 32'h3FE00002, 4'b1000, 7, 1'b0);
    run("tie_odd_rtz",    32'h3FE00001, 32'h3D200000, 1'b0, 1'b1, 32'h3FE00001, 4'b1000, 7, 1'b0);
    run("tie_even_rne",   32'h3FE00000, 32'h3D200000, 1'b0, 1'b0, 32'h3FE00000, 4'b1000, 7, 1'b0);
    run("far_sticky",     32'h3FE00000, 32'h00200000, 1'b0, 1'b0, 32'h3FE00000, 4'b1000, 7, 1'b0);
    run("underflow",      32'h00200001, 32'h00200000, 1'b1, 1'b0, 32'h00000000, 4'b0100, 7, 1'b0);

    // Special path
    run("nan_a",          32'h7FE00005, 32'h3FE00000, 1'b0, 1'b0, 32'h7FE00001, 4'b1000, 3, 1'b0);
    run("inf_minus_inf",  32'h7FE00000, 32'hFFE00000, 1'b0, 1'b0, 32'h7FE00001, 4'b1000, 3, 1'b0);
    run("inf_plus_one",   32'h7FE00000, 32'h3FE00000, 1'b0, 1'b0, 32'h7FE00000, 4'b0001, 3, 1'b0);
    run("zero_minus_one", 32'h00000000, 32'h3FE00000, 1'b1, 1'b0, 32'hBFE00000, 4'b0001, 3, 1'b0);
    // Back-to-back: start raised in the done cycle of the previous operation
    run("b2b_one_plus_0", 32'h3FE00000, 32'h00000000, 1'b0, 1'b0, 32'h3FE00000, 4'b0001, 3, 1'b1);

    // start_in pulsed while the unit is busy (ALIGN) must be ignored
    @(negedge clock_100KHz);
    op_A_in = 32'h3FE00000; op_B_in = 32'h3FE00000; op_in = 1'b0; rnd_mode_in = 1'b0;
    start_in = 1'b1;
    @(posedge clock_100KHz); #1;
    start_in = 1'b0;
    repeat (2) @(posedge clock_100KHz);
    #1;
    op_A_in = 32'h40000000;
    start_in = 1'b1;
    @(posedge clock_100KHz); #1;
    start_in = 1'b0;
    dones = 0;
    first_data = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock_100KHz); #1;
      if (done_out === 1'b1) begin
        if (dones == 0) first_data = data_out;
        dones++;
      end
    end
    check("busy_start.done_count", 32'(dones), 32'd1);
    check("busy_start.data", first_data, 32'h40000000);

    // Reset dropped while the operation sits in NORM
    @(negedge clock_100KHz);
    op_A_in = 32'h3FF00000; op_B_in = 32'h3FE00000; op_in = 1'b0;
    start_in = 1'b1;
    @(posedge clock_100KHz); #1;
    start_in = 1'b0;
    repeat (4) @(posedge clock_100KHz);
    #1;
    reset = 1'b0;
    #1;
    check("midreset.ready",  {31'd0, ready_out}, 32'd1);
    check("midreset.done",   {31'd0, done_out},  32'd0);
    check("midreset.data",   data_out,           32'h0);
    check("midreset.status", {28'd0, status_out}, 32'h0);
    repeat (2) @(posedge clock_100KHz);
    @(negedge clock_100KHz);
    reset = 1'b1;

    run("after_reset",    32'h3FE00000, 32'h3FE00000, 1'b0, 1'b0, 32'h40000000, 4'b0001, 7, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule : tb_fpu_addsub_param
`default_nettype wire
